led_frame_scheduler: RTL
========================

LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 SHALL have parameters: ROWS, default 8, matrix rows; COLS, default 8, matrix columns; both from the shared package.
REQ-002 SHALL have ports, clock and reset first:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse when the row scan wraps from row 7 to row 0
eng_req  in  1  engine requests a row write
eng_row  in  3  engine target row
eng_red  in  8  engine row data, red
eng_green  in  8  engine row data, green
eng_gnt  out  1  engine write accepted this cycle
eng_commit  in  1  engine pulse: back buffer is complete
commit_ack  out  1  one-cycle pulse when the swap has completed
usr_req  in  1  user requests a pixel write
usr_row  in  3  user pixel row
usr_col  in  3  user pixel column
usr_red  in  1  user pixel value, red
usr_green  in  1  user pixel value, green
usr_gnt  out  1  user write accepted this cycle
busy  out  1  high in the PEND and COPY states
red_array  out  8x8  front buffer, red, to the matrix driver
green_array  out  8x8  front buffer, green, to the matrix driver

Function
REQ-003 SHALL hold two 8x8 red/green buffer pairs, front and back; red_array and green_array SHALL always show the front buffer, driven directly from registers.
REQ-004 SHALL allow at most one back-buffer write per cycle, and only in the RUN state.
REQ-005 Grants SHALL be combinational from the requests and the round-robin pointer; a write SHALL take effect at the clock edge that ends the grant cycle.
REQ-006 A requester SHALL hold req and data stable until it sees its grant.
REQ-007 When both requesters assert req, the one not granted last SHALL win; the pointer SHALL update only when a grant is issued.
REQ-008 An engine write SHALL replace the full back-buffer row eng_row, red and green.
REQ-009 A user write SHALL change only bit [usr_row][usr_col] of the back-buffer red and green; all other bits SHALL be kept.
REQ-010 State machine SHALL be:
- RUN --eng_commit--> PEND
- PEND --frame_tick--> swap front and back, enter COPY
- COPY: copies the new front buffer into the back buffer, one row per cycle, rows 0..7, 8 cycles
- COPY --row 7 copied--> RUN, with commit_ack high for exactly that one cycle
REQ-011 No grants SHALL be issued in PEND or COPY; pending requests SHALL wait.
REQ-012 eng_commit SHALL be ignored outside RUN.
REQ-013 A frame_tick in the same cycle as an accepted eng_commit SHALL NOT swap; the swap SHALL happen at the next frame_tick.
REQ-014 An eng_commit in the same cycle as a grant SHALL let the write complete, then enter PEND.
REQ-015 The COPY row counter SHALL be 3 bits and SHALL wrap from 7 to 0 on leaving COPY.

Reset
REQ-016 While reset_n is low, in any state including mid-COPY, the block SHALL:
- clear both buffers, so red_array and green_array read 0
- enter RUN
- set the pointer to favour the engine
- drive eng_gnt, usr_gnt, commit_ack and busy to 0

Configuration
REQ-017 With LED_USR_OVERLAY_EN defined, the user port SHALL work as specified above.
REQ-018 Without LED_USR_OVERLAY_EN, usr_gnt SHALL be tied 0, the user inputs SHALL be ignored, the engine SHALL win every RUN cycle in which it requests, and the pointer SHALL be removed.

Structure
REQ-019 Package led_pkg SHALL hold ROWS, COLS, the state enum {RUN, PEND, COPY} and the pixel-row typedef.
REQ-020 The arbiter SHALL be a sub-module named rr_arb2: 2 requests in, 2 one-hot grants out, an enable input, pointer internal.

Verification
REQ-021 Engine writes row 3 red=8'hA5 green=8'h0F, then commit, then frame_tick -> red_array[3]=8'hA5 and green_array[3]=8'h0F appear at swap; commit_ack 8 cycles after swap; busy low after.
REQ-022 eng_req and usr_req both held for 4 cycles -> grants alternate E,U,E,U starting with the engine after reset.
REQ-023 User writes (2,5) red=1 while back row 2 red=8'h00 -> back row 2 red=8'h20 only; green unchanged.
REQ-024 eng_commit and frame_tick in the same cycle -> no swap; swap on the following frame_tick; a second commit during PEND causes no extra commit_ack.
REQ-025 reset_n low at COPY row 4 -> immediately all arrays 0, busy 0, state RUN; the first eng_req after release is granted in the same cycle.
REQ-026 Build without LED_USR_OVERLAY_EN, usr_req held high -> usr_gnt stays 0 and engine writes proceed every cycle.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared sizes, state encoding and pixel-row type for the LED frame scheduler
package led_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        COPY = 2'd2
    } state_e;

    typedef logic [COLS-1:0] pix_row_t;

endpackage

// File: rtl/led_frame_scheduler_rr_arb2.sv
// rtl/led_frame_scheduler_rr_arb2.sv - two-way round-robin arbiter, req[0] is favoured out of reset
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_q;
    logic prio_d;

    // prio_q high means req[1] wins a tie; it flips to the loser of each grant
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !prio_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - double-buffered LED frame store with engine/user writers; user port needs LED_USR_OVERLAY_EN
module led_frame_scheduler #(
    parameter int ROWS = led_pkg::ROWS,
    parameter int COLS = led_pkg::COLS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    input  logic                     eng_req,
    input  logic [$clog2(ROWS)-1:0]  eng_row,
    input  logic [COLS-1:0]          eng_red,
    input  logic [COLS-1:0]          eng_green,
    output logic                     eng_gnt,
    input  logic                     eng_commit,
    output logic                     commit_ack,
    input  logic                     usr_req,
    input  logic [$clog2(ROWS)-1:0]  usr_row,
    input  logic [$clog2(COLS)-1:0]  usr_col,
    input  logic                     usr_red,
    input  logic                     usr_green,
    output logic                     usr_gnt,
    output logic                     busy,
    output logic [ROWS*COLS-1:0]     red_array,
    output logic [ROWS*COLS-1:0]     green_array
);

    import led_pkg::*;

    localparam int RW = $clog2(ROWS);

    state_e          state_q;
    logic [RW-1:0]   row_q;
    logic            commit_ack_q;
    logic [COLS-1:0] front_r_q [ROWS];
    logic [COLS-1:0] front_g_q [ROWS];
    logic [COLS-1:0] back_r_q  [ROWS];
    logic [COLS-1:0] back_g_q  [ROWS];
    logic            run_en;

    // grants must drop while reset is held, even though state already reads RUN
    assign run_en = reset_n && (state_q == RUN);

`ifdef LED_USR_OVERLAY_EN
    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (run_en),
        .req     ({usr_req, eng_req}),
        .gnt     ({usr_gnt, eng_gnt})
    );
`else
    assign eng_gnt = run_en && eng_req;
    assign usr_gnt = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                front_r_q[r] <= '0;
                front_g_q[r] <= '0;
                back_r_q[r]  <= '0;
                back_g_q[r]  <= '0;
            end
            state_q      <= RUN;
            row_q        <= '0;
            commit_ack_q <= 1'b0;
        end else begin
            commit_ack_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (eng_gnt) begin
                        back_r_q[eng_row] <= eng_red;
                        back_g_q[eng_row] <= eng_green;
                    end
                    if (usr_gnt) begin
                        back_r_q[usr_row][usr_col] <= usr_red;
                        back_g_q[usr_row][usr_col] <= usr_green;
                    end
                    if (eng_commit) begin
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (frame_tick) begin
                        front_r_q <= back_r_q;
                        front_g_q <= back_g_q;
                        back_r_q  <= front_r_q;
                        back_g_q  <= front_g_q;
                        row_q     <= '0;
                        state_q   <= COPY;
                    end
                end
                COPY: begin
                    // resynchronise the back buffer so the engine edits the frame now on display
                    back_r_q[row_q] <= front_r_q[row_q];
                    back_g_q[row_q] <= front_g_q[row_q];
                    row_q           <= row_q + RW'(1);
                    if (row_q == RW'(ROWS - 1)) begin
                        state_q      <= RUN;
                        commit_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign busy       = (state_q != RUN);
    assign commit_ack = commit_ack_q;

    always_comb begin
        red_array   = '0;
        green_array = '0;
        for (int r = 0; r < ROWS; r++) begin
            red_array[r*COLS +: COLS]   = front_r_q[r];
            green_array[r*COLS +: COLS] = front_g_q[r];
        end
    end

endmodule
